// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit subtractor computing a - b - bin, LSB first.
// A single full-subtractor cell and a registered borrow process one bit per clock.
// A start/busy/done handshake frames each operation. diff/bout hold until the next DONE.
// Optional feature: define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    // Bit counter is at least one bit wide so that WIDTH=1 still has a register.
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SUB_OVF_EN
    logic [1:0]       sign_q, sign_d;   // {a sign, b sign} of the captured operands
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell working on the current LSBs and the registered borrow.
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    // Combinational full-subtractor cell and result shift.
    always_comb begin
        a_bit     = a_sh_q[0];
        b_bit     = b_sh_q[0];
        d_bit     = a_bit ^ b_bit ^ br_q;
        br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        // New difference bit enters from the MSB side so the LSB lands at bit 0 last.
        res_shift = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    end

    // Next-state logic for the FSM, datapath and registered outputs.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_OVF_EN
        sign_d  = sign_q;
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
`ifdef SUB_OVF_EN
                    sign_d  = {a[WIDTH-1], b[WIDTH-1]};
`endif
                end
            end

            StRun: begin
                // start is deliberately ignored here: no restart, no recapture.
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shift;
                br_d   = br_next;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_shift;
                    bout_d  = br_next;
`ifdef SUB_OVF_EN
                    // d_bit is the result MSB on the last bit.
                    ovf_d   = (sign_q[1] ^ sign_q[0]) & (d_bit ^ sign_q[1]);
`endif
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation and clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
            sign_q  <= 2'b00;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUB_OVF_EN
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances, scoreboard queues
// filled by the drivers and drained by per-instance monitors on the falling edge.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       s8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       s1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;
`ifdef SUB_OVF_EN
    logic       ovf8, ovf1;
`endif

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [7:0] held8_diff = '0;
    logic       held8_bout = 1'b0;
    logic       held1_diff = 1'b0;
    logic       held1_bout = 1'b0;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
`ifdef SUB_OVF_EN
        .bout  (bout8),
        .ovf   (ovf8)
`else
        .bout  (bout8)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
`ifdef SUB_OVF_EN
        .bout  (bout1),
        .ovf   (ovf1)
`else
        .bout  (bout1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic on w-bit values.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic bin, input int c);
        exp_t e;
        int   m, av, bv, dv, sa, sb, sd;
        m  = (1 << w) - 1;
        av = int'(a) & m;
        bv = int'(b) & m;
        dv = (av - bv - int'(bin)) & m;
        sa = (av >> (w - 1)) & 1;
        sb = (bv >> (w - 1)) & 1;
        sd = (dv >> (w - 1)) & 1;
        e.diff = 8'(dv);
        e.bout = (av < bv + int'(bin));
        e.ovf  = (sa != sb) && (sd != sa);
        e.cyc  = c;
        return e;
    endfunction

    // WIDTH=8 monitor: checks results, done timing and that outputs hold between DONEs.
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            held8_diff = '0;
            held8_bout = 1'b0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                chk("u8 spurious done", 32'(done8), 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("u8 done cycle", cyc, e8.cyc);
                chk("u8 diff", 32'(diff8), 32'(e8.diff));
                chk("u8 bout", 32'(bout8), 32'(e8.bout));
`ifdef SUB_OVF_EN
                chk("u8 ovf", 32'(ovf8), 32'(e8.ovf));
`endif
                held8_diff = e8.diff;
                held8_bout = e8.bout;
            end
        end else begin
            chk("u8 hold diff", 32'(diff8), 32'(held8_diff));
            chk("u8 hold bout", 32'(bout8), 32'(held8_bout));
            if (q8.size() > 0 && cyc > q8[0].cyc) begin
                chk("u8 done timeout", cyc, q8[0].cyc);
                void'(q8.pop_front());
            end
        end
    end

    // WIDTH=1 monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            held1_diff = 1'b0;
            held1_bout = 1'b0;
        end else if (done1) begin
            if (q1.size() == 0) begin
                chk("u1 spurious done", 32'(done1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("u1 done cycle", cyc, e1.cyc);
                chk("u1 diff", 32'(diff1), 32'(e1.diff));
                chk("u1 bout", 32'(bout1), 32'(e1.bout));
`ifdef SUB_OVF_EN
                chk("u1 ovf", 32'(ovf1), 32'(e1.ovf));
`endif
                held1_diff = e1.diff[0];
                held1_bout = e1.bout;
            end
        end else begin
            chk("u1 hold diff", 32'(diff1), 32'(held1_diff));
            if (q1.size() > 0 && cyc > q1[0].cyc) begin
                chk("u1 done timeout", cyc, q1[0].cyc);
                void'(q1.pop_front());
            end
        end
    end

    // Issues one start; returns at the falling edge where done should be visible.
    // b2b drives the next start in that DONE cycle; glitch pulses start mid-run.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input bit b2b, input bit glitch);
        if (!b2b) @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; s8 = 1'b1;
        q8.push_back(model(8, a, b, bin, cyc + 1 + 8));
        @(negedge clk);
        s8 = 1'b0;
        if (glitch) begin
            repeat (2) @(negedge clk);
            a8 = ~a; b8 = a; bin8 = ~bin; s8 = 1'b1;
            @(negedge clk);
            s8 = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic issue1(input logic a, input logic b, input logic bin);
        @(negedge clk);
        a1 = a; b1 = b; bin1 = bin; s1 = 1'b1;
        q1.push_back(model(1, {7'd0, a}, {7'd0, b}, bin, cyc + 2));
        @(negedge clk);
        s1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy8", 32'(busy8), 32'd0);
        chk("reset done8", 32'(done8), 32'd0);
        chk("reset diff8", 32'(diff8), 32'd0);
        chk("reset bout8", 32'(bout8), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset diff1", 32'(diff1), 32'd0);
`ifdef SUB_OVF_EN
        chk("reset ovf8", 32'(ovf8), 32'd0);
`endif
        #2 rst_n = 1'b1;

        // WIDTH=1 full truth table.
        for (int i = 0; i < 8; i++) issue1(i[2], i[1], i[0]);

        // WIDTH=8 directed cases.
        issue8(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
        issue8(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
        issue8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        issue8(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
        issue8(8'h10, 8'h01, 1'b0, 1'b0, 1'b0);
        // Start pulsed mid-run must be ignored.
        issue8(8'h5A, 8'h33, 1'b1, 1'b0, 1'b1);
        // Start in the DONE cycle: back-to-back operations.
        issue8(8'hC4, 8'h21, 1'b0, 1'b1, 1'b0);
        issue8(8'h12, 8'hF0, 1'b1, 1'b1, 1'b0);

        // Reset at cycle 4 of a run clears outputs asynchronously.
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy8", 32'(busy8), 32'd0);
        chk("async rst done8", 32'(done8), 32'd0);
        chk("async rst diff8", 32'(diff8), 32'd0);
        chk("async rst bout8", 32'(bout8), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Randomised operations, some back-to-back.
        for (int i = 0; i < 40; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom), (i > 0) && ($urandom_range(0, 1) == 1),
                   1'b0);
            if ((i % 4) == 0) issue1(1'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("u8 leftover expected", q8.size(), 32'd0);
        chk("u1 leftover expected", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
